scsi_inq_evt_arb: RTL and testbench
===================================

Name: scsi_inq_evt_arb

Overview:
- Shares one event-record write port, feeding the misc FIFO, between N per-channel SCSI Inquiry extractors.
- Each extractor emits single-cycle IS_CMD/IS_RSP pulses with D_ID, S_ID, OX_ID and the SOP timestamp of the frame.
- The block captures each pulse into a 2-entry per-channel queue and arbitrates round-robin into a registered valid/ready output.
- It counts events dropped on queue overflow, per channel.

Parameters:
NCH, 4, number of extractor channels (1..64)
CNT_W, 16, width of each per-channel drop counter

Ports:
iCLK  in  1  clock
iRST_N  in  1  reset; one clock; reset is asynchronous and active-low
iIS_CMD  in  NCH  per-channel Inquiry-command pulse (1 cycle)
iIS_RSP  in  NCH  per-channel non-command pulse (1 cycle)
iD_ID  in  NCH*24  per-channel D_ID, channel k at [24k+23:24k]
iS_ID  in  NCH*24  per-channel S_ID
iOX_ID  in  NCH*16  per-channel OX_ID
iLAST_TS  in  NCH*56  per-channel SOP timestamp
iCH_EN  in  NCH  per-channel capture enable (static config register)
iCLR_CNT  in  1  synchronous pulse, clears all drop counters
iEVT_READY  in  1  downstream FIFO accepts record
oEVT_VALID  out  1  record valid
oEVT_DATA  out  128  record: [127:126] type (01 cmd, 10 rsp), [125:120] channel index, [119:64] TS, [63:40] D_ID, [39:16] S_ID, [15:0] OX_ID
oDROP_CNT  out  NCH*CNT_W  per-channel saturating drop counters
oBUSY  out  1  any queue non-empty or oEVT_VALID high

Behaviour:
- Reset values:
  - oEVT_VALID=0, oEVT_DATA=0, oDROP_CNT=0, oBUSY=0.
  - All queues are empty. RR pointer = NCH-1, so channel 0 has first priority.
- Capture:
  - In cycle t, channel k captures if iCH_EN[k] and (iIS_CMD[k] or iIS_RSP[k]).
  - The record is built from the channel-k slices in the same cycle.
  - If both pulses are high, the cmd type wins.
  - The entry is written into queue k at edge t+1.
- Queue (per channel):
  - 2 entries, FIFO order, independent read/write pointers plus a count (0..2).
  - A capture into a full queue is dropped, and oDROP_CNT[k] increments, saturating at all-ones.
  - A capture and a pop on the same full queue in the same cycle: the pop frees a slot and the capture is accepted, no drop.
  - A capture into an empty queue is poppable from the next cycle. There is no same-cycle bypass.
- Arbitration:
  - Grant is allowed when the output register is free: oEVT_VALID=0, or oEVT_VALID=1 and iEVT_READY=1.
  - Among non-empty queues, search round-robin starting at RR pointer+1 (mod NCH).
  - On grant, pop the head entry into the output register and set RR pointer = granted index.
  - No grant occurs while the output is stalled.
- Output handshake:
  - oEVT_VALID/oEVT_DATA are registered and held stable until iEVT_READY is sampled high.
  - Throughput is 1 record/cycle when ready is held high.
  - Latency from a pulse in cycle t to oEVT_VALID: 2 cycles (valid in cycle t+2) when uncontended.
  - Accept with no pending queue: oEVT_VALID falls next cycle.
- iCH_EN deassert mid-operation: new captures on that channel are blocked and not counted as drops. Already queued entries still drain.
- iCLR_CNT:
  - Clears all counters next edge.
  - A drop in the same cycle as iCLR_CNT leaves that counter = 1.
- Channel index field: zero-extended to 6 bits.
- oBUSY: combinational OR of (queue count != 0) over all channels, and oEVT_VALID.
- Async reset mid-operation: all queued and output records are discarded immediately. Counters return to 0.

Optional Feature:
- Macro: SCSI_INQ_ARB_RSP_FILTER_EN.
- When defined:
  - iIS_RSP pulses are ignored entirely: not queued, not counted as drops.
  - Only type 01 records are emitted.
  - A simultaneous cmd+rsp pulse captures as cmd.
- When undefined: both types are captured as described above.

Test Plan:
- Single cmd on ch2 (D_ID=0x010203, S_ID=0x0A0B0C, OX_ID=0x1234, TS=0x55), ready=1 -> oEVT_VALID in cycle t+2 with data {2'b01, 6'd2, 56'h55, 24'h010203, 24'h0A0B0C, 16'h1234} for exactly 1 cycle.
- Cmd pulses on ch0..ch3 in the same cycle, ready=1 -> 4 consecutive records in order ch0, ch1, ch2, ch3; oBUSY drops after the last accept.
- ready=0, 3 pulses on ch1 in consecutive cycles -> first 2 queued, oDROP_CNT[1]=1. Release ready -> exactly 2 ch1 records, data held stable while stalled.
- Counter saturation with CNT_W=2: 5 drops on ch0 -> counter reads 3. iCLR_CNT coincident with a drop -> counter = 1.
- iCH_EN[3]=0 with a pulse on ch3 -> no record, no drop. Disable ch3 while 2 entries are queued -> both still emitted.
- With SCSI_INQ_ARB_RSP_FILTER_EN defined: rsp pulse on ch0 -> no record, no drop. Without it -> one record with type 2'b10.

Source files
------------

// File: rtl/scsi_inq_evt_arb.sv
// Round-robin arbiter merging per-channel SCSI Inquiry events into one registered valid/ready record port.
// Optional build macro SCSI_INQ_ARB_RSP_FILTER_EN: when defined, response pulses are ignored.
module scsi_inq_evt_arb #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic [NCH-1:0]         iIS_CMD,
    input  logic [NCH-1:0]         iIS_RSP,
    input  logic [NCH*24-1:0]      iD_ID,
    input  logic [NCH*24-1:0]      iS_ID,
    input  logic [NCH*16-1:0]      iOX_ID,
    input  logic [NCH*56-1:0]      iLAST_TS,
    input  logic [NCH-1:0]         iCH_EN,
    input  logic                   iCLR_CNT,
    input  logic                   iEVT_READY,
    output logic                   oEVT_VALID,
    output logic [127:0]           oEVT_DATA,
    output logic [NCH*CNT_W-1:0]   oDROP_CNT,
    output logic                   oBUSY
);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [127:0]     qMem_r [NCH][2];
    logic [1:0]       qCnt_r [NCH];
    logic [NCH-1:0]   wrPtr_r;
    logic [NCH-1:0]   rdPtr_r;
    logic [IDX_W-1:0] rrPtr_r;

    logic [127:0]     capRec_s [NCH];
    logic [NCH-1:0]   cap_s;
    logic [NCH-1:0]   acc_s;
    logic [NCH-1:0]   drop_s;
    logic [NCH-1:0]   pop_s;
    logic [NCH-1:0]   nonEmpty_s;
    logic             outFree_s;
    logic             grantVld_s;
    logic [IDX_W-1:0] grantIdx_s;
    logic [127:0]     headRec_s;

    // Per-channel capture qualification and record assembly
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
`ifdef SCSI_INQ_ARB_RSP_FILTER_EN
            cap_s[k] = iCH_EN[k] & iIS_CMD[k];
`else
            cap_s[k] = iCH_EN[k] & (iIS_CMD[k] | iIS_RSP[k]);
`endif
            capRec_s[k] = {(iIS_CMD[k] ? 2'b01 : 2'b10), 6'(k), iLAST_TS[56*k +: 56],
                           iD_ID[24*k +: 24], iS_ID[24*k +: 24], iOX_ID[16*k +: 16]};
            nonEmpty_s[k] = (qCnt_r[k] != 2'd0);
        end
    end

    // Round-robin search from rrPtr_r+1; scanning downward lets the nearest hit win
    always_comb begin
        logic [IDX_W-1:0] idx;
        grantVld_s = 1'b0;
        grantIdx_s = {IDX_W{1'b0}};
        idx        = {IDX_W{1'b0}};
        for (int i = NCH; i >= 1; i--) begin
            idx        = IDX_W'((int'(rrPtr_r) + i) % NCH);
            grantIdx_s = nonEmpty_s[idx] ? idx : grantIdx_s;
            grantVld_s = grantVld_s | nonEmpty_s[idx];
        end
    end

    // Pop/accept/drop decisions; a pop on a full queue makes room for a same-cycle capture
    always_comb begin
        outFree_s = ~oEVT_VALID | iEVT_READY;
        headRec_s = 128'd0;
        for (int k = 0; k < NCH; k++) begin
            pop_s[k]  = outFree_s & grantVld_s & (int'(grantIdx_s) == k);
            acc_s[k]  = cap_s[k] & ((qCnt_r[k] != 2'd2) | pop_s[k]);
            drop_s[k] = cap_s[k] & ~acc_s[k];
            headRec_s = (int'(grantIdx_s) == k) ? qMem_r[k][rdPtr_r[k]] : headRec_s;
        end
    end

    // Queue storage, no reset needed since occupancy is tracked separately
    always_ff @(posedge iCLK) begin
        for (int k = 0; k < NCH; k++) begin
            if (acc_s[k]) begin
                qMem_r[k][wrPtr_r[k]] <= capRec_s[k];
            end
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wrPtr_r <= {NCH{1'b0}};
            rdPtr_r <= {NCH{1'b0}};
            for (int k = 0; k < NCH; k++) begin
                qCnt_r[k] <= 2'd0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (acc_s[k]) begin
                    wrPtr_r[k] <= ~wrPtr_r[k];
                end
                if (pop_s[k]) begin
                    rdPtr_r[k] <= ~rdPtr_r[k];
                end
                qCnt_r[k] <= qCnt_r[k] + {1'b0, acc_s[k]} - {1'b0, pop_s[k]};
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oEVT_VALID <= 1'b0;
            oEVT_DATA  <= 128'd0;
            rrPtr_r    <= IDX_W'(NCH - 1);
        end else if (outFree_s) begin
            if (grantVld_s) begin
                oEVT_VALID <= 1'b1;
                oEVT_DATA  <= headRec_s;
                rrPtr_r    <= grantIdx_s;
            end else begin
                oEVT_VALID <= 1'b0;
            end
        end
    end

    // Saturating drop counters; a drop coincident with clear restarts at one
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oDROP_CNT <= {(NCH*CNT_W){1'b0}};
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (iCLR_CNT) begin
                    oDROP_CNT[CNT_W*k +: CNT_W] <= drop_s[k] ? CNT_W'(1'b1) : {CNT_W{1'b0}};
                end else if (drop_s[k] && (oDROP_CNT[CNT_W*k +: CNT_W] != CNT_MAX)) begin
                    oDROP_CNT[CNT_W*k +: CNT_W] <= oDROP_CNT[CNT_W*k +: CNT_W] + CNT_W'(1'b1);
                end
            end
        end
    end

    // Activity flag
    always_comb begin
        oBUSY = oEVT_VALID | (|nonEmpty_s);
    end

endmodule

// File: tb/tb_scsi_inq_evt_arb.sv
// Scoreboard bench for scsi_inq_evt_arb (NCH=4, CNT_W=2 to reach counter saturation quickly).
module tb_scsi_inq_evt_arb;
    localparam int NCH   = 4;
    localparam int CNT_W = 2;

    logic                 iCLK = 1'b0;
    logic                 iRST_N = 1'b0;
    logic [NCH-1:0]       iIS_CMD = '0;
    logic [NCH-1:0]       iIS_RSP = '0;
    logic [NCH*24-1:0]    iD_ID = '0;
    logic [NCH*24-1:0]    iS_ID = '0;
    logic [NCH*16-1:0]    iOX_ID = '0;
    logic [NCH*56-1:0]    iLAST_TS = '0;
    logic [NCH-1:0]       iCH_EN = '1;
    logic                 iCLR_CNT = 1'b0;
    logic                 iEVT_READY = 1'b1;
    logic                 oEVT_VALID;
    logic [127:0]         oEVT_DATA;
    logic [NCH*CNT_W-1:0] oDROP_CNT;
    logic                 oBUSY;

    int nChecks = 0;
    int nFails  = 0;
    logic [127:0] expQ[$];
    logic [127:0] heldData = 128'd0;
    logic         heldVld  = 1'b0;

    scsi_inq_evt_arb #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iIS_CMD(iIS_CMD), .iIS_RSP(iIS_RSP),
        .iD_ID(iD_ID), .iS_ID(iS_ID), .iOX_ID(iOX_ID), .iLAST_TS(iLAST_TS),
        .iCH_EN(iCH_EN), .iCLR_CNT(iCLR_CNT), .iEVT_READY(iEVT_READY),
        .oEVT_VALID(oEVT_VALID), .oEVT_DATA(oEVT_DATA), .oDROP_CNT(oDROP_CNT), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mkRec(input logic [1:0] t, input int ch, input logic [23:0] d,
                                           input logic [23:0] s, input logic [15:0] ox, input logic [55:0] ts);
        return {t, 6'(ch), ts, d, s, ox};
    endfunction

    function automatic logic [CNT_W-1:0] dropCnt(input int ch);
        return oDROP_CNT[CNT_W*ch +: CNT_W];
    endfunction

    task automatic setCh(input int ch, input logic [23:0] d, input logic [23:0] s,
                         input logic [15:0] ox, input logic [55:0] ts);
        iD_ID[24*ch +: 24]    = d;
        iS_ID[24*ch +: 24]    = s;
        iOX_ID[16*ch +: 16]   = ox;
        iLAST_TS[56*ch +: 56] = ts;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    // one-cycle pulse starting at posedge+1, returns at the following posedge+1
    task automatic drive(input logic [NCH-1:0] cmd, input logic [NCH-1:0] rsp);
        iIS_CMD = cmd;
        iIS_RSP = rsp;
        tick(1);
        iIS_CMD = '0;
        iIS_RSP = '0;
    endtask

    task automatic doReset();
        iRST_N   = 1'b0;
        iIS_CMD  = '0;
        iIS_RSP  = '0;
        iCLR_CNT = 1'b0;
        iCH_EN   = '1;
        expQ.delete();
        tick(1);
        iRST_N = 1'b1;
        tick(1);
    endtask

    task automatic drainWait(input string tag);
        int n = 0;
        while ((expQ.size() != 0 || oEVT_VALID) && n < 60) begin
            tick(1);
            n++;
        end
        tick(2);
        checkVal(tag, 128'(expQ.size()), 128'd0);
    endtask

    // Monitor: compare accepted records against the scoreboard and check stall stability
    always @(negedge iCLK) begin
        if (!iRST_N) begin
            heldVld = 1'b0;
        end else begin
            if (heldVld) begin
                checkVal("stall_valid", 128'(oEVT_VALID), 128'd1);
                checkVal("stall_data", oEVT_DATA, heldData);
            end
            if (oEVT_VALID && iEVT_READY) begin
                if (expQ.size() == 0) checkVal("spurious_valid", 128'(oEVT_VALID), 128'd0);
                else checkVal("record", oEVT_DATA, expQ.pop_front());
            end
            heldVld  = oEVT_VALID && !iEVT_READY;
            heldData = oEVT_DATA;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] d, s;
        logic [15:0] ox;
        logic [55:0] ts;

        // reset state
        #2;
        checkVal("rst_valid", 128'(oEVT_VALID), 128'd0);
        checkVal("rst_data", oEVT_DATA, 128'd0);
        checkVal("rst_drop", 128'(oDROP_CNT), 128'd0);
        checkVal("rst_busy", 128'(oBUSY), 128'd0);
        tick(2);
        iRST_N = 1'b1;
        tick(1);

        // single cmd on ch2: valid exactly in cycle t+2
        setCh(2, 24'h010203, 24'h0A0B0C, 16'h1234, 56'h55);
        expQ.push_back(mkRec(2'b01, 2, 24'h010203, 24'h0A0B0C, 16'h1234, 56'h55));
        drive(4'b0100, 4'b0000);
        #3 checkVal("lat_t1", 128'(oEVT_VALID), 128'd0);
        tick(1);
        #3 checkVal("lat_t2", 128'(oEVT_VALID), 128'd1);
        checkVal("t1_data", oEVT_DATA, {2'b01, 6'd2, 56'h55, 24'h010203, 24'h0A0B0C, 16'h1234});
        tick(1);
        #3 checkVal("lat_t3", 128'(oEVT_VALID), 128'd0);
        tick(1);

        // all four channels at once: order ch0..ch3 from reset, busy drops after last
        doReset();
        for (int k = 0; k < NCH; k++) begin
            d = 24'($urandom); s = 24'($urandom); ox = 16'($urandom); ts = {24'($urandom), 32'($urandom)};
            setCh(k, d, s, ox, ts);
            expQ.push_back(mkRec(2'b01, k, d, s, ox, ts));
        end
        drive(4'b1111, 4'b0000);
        #3 checkVal("busy_t1", 128'(oBUSY), 128'd1);
        tick(4);
        #3 checkVal("busy_last", 128'(oBUSY), 128'd1);
        tick(1);
        #3 checkVal("busy_idle", 128'(oBUSY), 128'd0);
        tick(1);
        drainWait("drain_rr");

        // stall: ch0 holds output, 3 ch1 pulses -> 2 queued, 1 drop
        doReset();
        iEVT_READY = 1'b0;
        setCh(0, 24'hAAAAAA, 24'hBBBBBB, 16'h00F0, 56'h1);
        expQ.push_back(mkRec(2'b01, 0, 24'hAAAAAA, 24'hBBBBBB, 16'h00F0, 56'h1));
        drive(4'b0001, 4'b0000);
        tick(2);
        for (int i = 0; i < 3; i++) begin
            setCh(1, 24'h111111, 24'h222222, 16'(i + 1), 56'(100 + i));
            if (i < 2) expQ.push_back(mkRec(2'b01, 1, 24'h111111, 24'h222222, 16'(i + 1), 56'(100 + i)));
            drive(4'b0010, 4'b0000);
        end
        checkVal("drop_ch1", 128'(dropCnt(1)), 128'd1);
        checkVal("drop_ch0", 128'(dropCnt(0)), 128'd0);
        tick(3);
        iEVT_READY = 1'b1;
        drainWait("drain_stall");
        checkVal("drop_ch1_after", 128'(dropCnt(1)), 128'd1);

        // saturation at CNT_W=2, clear coincident with drop
        doReset();
        iEVT_READY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            setCh(0, 24'h0C0C0C, 24'h0D0D0D, 16'(i), 56'(i));
            if (i < 3) expQ.push_back(mkRec(2'b01, 0, 24'h0C0C0C, 24'h0D0D0D, 16'(i), 56'(i)));
            drive(4'b0001, 4'b0000);
            if (i == 4) checkVal("drop_two", 128'(dropCnt(0)), 128'd2);
        end
        checkVal("drop_sat", 128'(dropCnt(0)), 128'd3);
        iCLR_CNT = 1'b1;
        drive(4'b0001, 4'b0000);
        iCLR_CNT = 1'b0;
        checkVal("clr_with_drop", 128'(dropCnt(0)), 128'd1);
        iCLR_CNT = 1'b1;
        tick(1);
        iCLR_CNT = 1'b0;
        checkVal("clr_plain", 128'(dropCnt(0)), 128'd0);
        iEVT_READY = 1'b1;
        drainWait("drain_sat");

        // channel enable: disabled pulse ignored; queued entries drain after disable
        doReset();
        iCH_EN = 4'b0111;
        drive(4'b1000, 4'b0000);
        tick(4);
        checkVal("dis_busy", 128'(oBUSY), 128'd0);
        checkVal("dis_drop", 128'(dropCnt(3)), 128'd0);
        iCH_EN = 4'b1111;
        iEVT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setCh(3, 24'h333333, 24'h444444, 16'(16'h3000 + i), 56'(i + 7));
            expQ.push_back(mkRec(2'b01, 3, 24'h333333, 24'h444444, 16'(16'h3000 + i), 56'(i + 7)));
            drive(4'b1000, 4'b0000);
        end
        iCH_EN = 4'b0111;
        drive(4'b1000, 4'b0000);
        checkVal("dis_full_drop", 128'(dropCnt(3)), 128'd0);
        iEVT_READY = 1'b1;
        drainWait("drain_dis");

        // response pulses and cmd+rsp precedence
        doReset();
        setCh(0, 24'h0F0F0F, 24'hF0F0F0, 16'h5A5A, 56'h77);
`ifndef SCSI_INQ_ARB_RSP_FILTER_EN
        expQ.push_back(mkRec(2'b10, 0, 24'h0F0F0F, 24'hF0F0F0, 16'h5A5A, 56'h77));
`endif
        drive(4'b0000, 4'b0001);
        drainWait("drain_rsp");
        checkVal("rsp_drop", 128'(dropCnt(0)), 128'd0);
        expQ.push_back(mkRec(2'b01, 0, 24'h0F0F0F, 24'hF0F0F0, 16'h5A5A, 56'h77));
        drive(4'b0001, 4'b0001);
        drainWait("drain_both");

        // async reset mid-operation discards everything
        iEVT_READY = 1'b0;
        drive(4'b0011, 4'b0000);
        expQ.push_back(mkRec(2'b01, 0, 24'h0F0F0F, 24'hF0F0F0, 16'h5A5A, 56'h77));
        tick(2);
        checkVal("pre_rst_busy", 128'(oBUSY), 128'd1);
        iRST_N = 1'b0;
        expQ.delete();
        #1;
        checkVal("mid_rst_valid", 128'(oEVT_VALID), 128'd0);
        checkVal("mid_rst_busy", 128'(oBUSY), 128'd0);
        checkVal("mid_rst_data", oEVT_DATA, 128'd0);
        tick(1);
        iRST_N = 1'b1;
        iEVT_READY = 1'b1;
        tick(1);
        setCh(1, 24'h123456, 24'h654321, 16'hBEEF, 56'hCAFE);
        expQ.push_back(mkRec(2'b01, 1, 24'h123456, 24'h654321, 16'hBEEF, 56'hCAFE));
        drive(4'b0010, 4'b0000);
        drainWait("drain_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
